// File: rtl/seq_detect_sched.sv
// Round-robin scheduler that feeds one requester word at a time, MSB-first, through a
// shared consecutive-ones run detector and reports per-word hit/end counts.
module seq_detect_sched #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data,
  output logic [N_REQ-1:0]          gnt,
  output logic                      busy,
  output logic                      res_valid,
  output logic [ID_W-1:0]           res_id,
  output logic [CNT_W-1:0]          res_hits,
  output logic [CNT_W-1:0]          res_ends,
  output logic [1:0]                det_state
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef enum logic [1:0] {D0, D1, D2, D3} det_t;

  state_t             state_q, state_d;
  det_t               det_q, det_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   hits_q, hits_d, ends_q, ends_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               res_valid_q, res_valid_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic [CNT_W-1:0]   res_hits_q, res_hits_d, res_ends_q, res_ends_d;
  logic [ID_W-1:0]    win;
  logic [DATA_W-1:0]  win_word;
  logic               bit_in;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Arbitration: first set request after the last winner, wrapping around
  always_comb begin
    int   idx;
    logic found;
    win      = '0;
    found    = 1'b0;
    idx      = 0;
    win_word = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[ID_W'(idx)]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (win == ID_W'(i)) win_word = data[i*DATA_W +: DATA_W];
    end
  end

  // Control FSM and run detector next-state
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    det_d       = det_q;
    hits_d      = hits_q;
    ends_d      = ends_q;
    gnt_d       = '0;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_hits_d  = res_hits_q;
    res_ends_d  = res_ends_q;
    bit_in      = shreg_q[DATA_W-1];
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d     = N_REQ'(1) << win;
          shreg_d   = win_word;
          last_d    = win;
          bit_cnt_d = '0;
          det_d     = D0;
          hits_d    = '0;
          ends_d    = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d   = shreg_q << 1;
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        if (bit_in) begin
          if (det_q == D2) hits_d = sat_inc(hits_q);
          if (det_q != D3) det_d = det_t'(det_q + 2'd1);
        end else begin
          if (det_q == D3) ends_d = sat_inc(ends_q);
          det_d = D0;
        end
        // Final bit: its own increment is already folded into hits_d/ends_d
        if (bit_cnt_q == BC_W'(DATA_W-1)) begin
          res_valid_d = 1'b1;
          res_id_d    = last_q;
          res_hits_d  = hits_d;
          res_ends_d  = ends_d;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= ID_W'(N_REQ-1);
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      det_q       <= D0;
      hits_q      <= '0;
      ends_q      <= '0;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_hits_q  <= '0;
      res_ends_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      det_q       <= det_d;
      hits_q      <= hits_d;
      ends_q      <= ends_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_hits_q  <= res_hits_d;
      res_ends_q  <= res_ends_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q == SHIFT);
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_hits  = res_hits_q;
  assign res_ends  = res_ends_q;
  assign det_state = det_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched: reset values, a vector table of words, round-robin and
// mid-word reset sequences, then random traffic against a run-counting reference model.
module tb_seq_detect_sched;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data;
  logic [N_REQ-1:0]        gnt;
  logic                    busy;
  logic                    res_valid;
  logic [1:0]              res_id;
  logic [CNT_W-1:0]        res_hits;
  logic [CNT_W-1:0]        res_ends;
  logic [1:0]              det_state;

  seq_detect_sched #(.N_REQ(N_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt), .busy(busy),
    .res_valid(res_valid), .res_id(res_id), .res_hits(res_hits),
    .res_ends(res_ends), .det_state(det_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int m_last = N_REQ - 1;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] word;
    int         exp_id;
    int         exp_hits;
    int         exp_ends;
    int         exp_det;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Counts runs of ones directly: a run reaching length 3 is a hit, a run of 3+
  // closed by a zero is an end; tail is the trailing run length clipped to 3.
  function automatic void ref_word(input logic [7:0] w, output int h, output int e, output int t);
    int run;
    run = 0; h = 0; e = 0;
    for (int i = 7; i >= 0; i--) begin
      if (w[i]) begin
        run++;
        if (run == 3) h++;
      end else begin
        if (run >= 3) e++;
        run = 0;
      end
    end
    if (h > 15) h = 15;
    if (e > 15) e = 15;
    t = (run > 3) ? 3 : run;
  endfunction

  function automatic int ref_arb(input logic [3:0] mask, input int last);
    for (int k = 1; k <= N_REQ; k++) begin
      if (mask[(last + k) % N_REQ]) return (last + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    req = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_last = N_REQ - 1;
  endtask

  task automatic do_txn(input logic [3:0] mask, input int exp_id, input int eh, input int ee,
                        input int et, input string nm);
    bit got;
    int lat;
    req = mask;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (gnt != 0) got = 1;
    end
    chk({nm, ".gnt"}, 32'(gnt), 32'(1) << exp_id);
    chk({nm, ".busy_on"}, 32'(busy), 32'd1);
    req = '0;
    got = 0;
    lat = 0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (n == 1) chk({nm, ".gnt_pulse"}, 32'(gnt), 32'd0);
      if (res_valid) begin
        got = 1;
        lat = n;
      end
    end
    chk({nm, ".latency"}, 32'(lat), 32'(DATA_W));
    chk({nm, ".res_id"}, 32'(res_id), 32'(exp_id));
    chk({nm, ".res_hits"}, 32'(res_hits), 32'(eh));
    chk({nm, ".res_ends"}, 32'(res_ends), 32'(ee));
    chk({nm, ".det_state"}, 32'(det_state), 32'(et));
    chk({nm, ".busy_off"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({nm, ".rv_pulse"}, 32'(res_valid), 32'd0);
    chk({nm, ".hold_hits"}, 32'(res_hits), 32'(eh));
    m_last = exp_id;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int order[5];
    int prev_cyc;
    bit got;
    int w, h, e, t;
    logic [7:0] wd;
    logic [3:0] mask;

    vecs[0] = '{4'b0001, 8'b1110_1110, 0, 2, 2, 0};
    vecs[1] = '{4'b0100, 8'hFF,        2, 1, 0, 3};
    vecs[2] = '{4'b0010, 8'h00,        1, 0, 0, 0};
    vecs[3] = '{4'b1000, 8'b1101_1011, 3, 0, 0, 2};
    vecs[4] = '{4'b1010, 8'b0111_1000, 1, 1, 1, 0};
    vecs[5] = '{4'b1010, 8'b1111_0111, 3, 2, 1, 3};
    vecs[6] = '{4'b1010, 8'b1011_1101, 1, 1, 1, 1};
    order   = '{0, 1, 2, 3, 0};

    rst  = 1'b0;
    req  = '0;
    data = '0;
    repeat (2) @(negedge clk);
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.res_valid", 32'(res_valid), 32'd0);
    chk("rst.res_id", 32'(res_id), 32'd0);
    chk("rst.res_hits", 32'(res_hits), 32'd0);
    chk("rst.res_ends", 32'(res_ends), 32'd0);
    chk("rst.det_state", 32'(det_state), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle.gnt", 32'(gnt), 32'd0);

    for (int i = 0; i < 7; i++) begin
      data[vecs[i].exp_id*DATA_W +: DATA_W] = vecs[i].word;
      do_txn(vecs[i].mask, vecs[i].exp_id, vecs[i].exp_hits, vecs[i].exp_ends,
             vecs[i].exp_det, $sformatf("vec%0d", i));
    end

    // Round robin with all four requesters held
    do_reset();
    req = 4'hF;
    prev_cyc = 0;
    for (int g = 0; g < 5; g++) begin
      got = 0;
      for (int n = 0; n < 30 && !got; n++) begin
        @(negedge clk);
        if (gnt != 0) got = 1;
      end
      chk($sformatf("rr%0d.gnt", g), 32'(gnt), 32'(1) << order[g]);
      if (g > 0) chk($sformatf("rr%0d.gap", g), 32'(cyc - prev_cyc), 32'(DATA_W + 1));
      prev_cyc = cyc;
      w = order[g];
      req[w] = 1'b0;
      @(negedge clk);
      req[w] = 1'b1;
    end
    req = '0;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (res_valid) got = 1;
    end
    chk("rr.final_done", 32'(got), 32'd1);
    m_last = 0;

    // Reset in the middle of a word
    data[2*DATA_W +: DATA_W] = 8'hFF;
    req = 4'b0100;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (gnt != 0) got = 1;
    end
    chk("mid.gnt", 32'(gnt), 32'b0100);
    req = '0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid.outs", {gnt, busy, res_valid, res_id, res_hits, res_ends, det_state}, 32'd0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("mid.no_rv", 32'(res_valid), 32'd0);
    end
    rst = 1'b1;
    m_last = N_REQ - 1;
    data[3*DATA_W +: DATA_W] = 8'b0011_1001;
    ref_word(8'b0011_1001, h, e, t);
    do_txn(4'b1000, 3, h, e, t, "post_rst_a");
    data[0*DATA_W +: DATA_W] = 8'b1111_1110;
    ref_word(8'b1111_1110, h, e, t);
    do_txn(4'b1001, 0, h, e, t, "post_rst_b");

    // Random traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      mask = 4'($urandom_range(1, 15));
      data = $urandom;
      w = ref_arb(mask, m_last);
      wd = data[w*DATA_W +: DATA_W];
      ref_word(wd, h, e, t);
      do_txn(mask, w, h, e, t, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
